rename_rat_ckpt: RTL

RENAME_RAT_CKPT -- requirements
Module: rename_rat_ckpt

---
 rtl/rename_rat_ckpt_if.sv | 42 ++++
 rtl/rename_rat_ckpt.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/rename_rat_ckpt_if.sv
// Rename-port bundle for rename_rat_ckpt: rename lookups/writes, snapshot control,
// commit writes and recovery. The master side drives requests; the slave is the RAT.
interface rename_rat_ckpt_if #(
    parameter int unsigned RN_WIDTH = 2,
    parameter int unsigned AREG_NUM = 32,
    parameter int unsigned PREG_W   = 7,
    parameter int unsigned CKPT_NUM = 4
);
    localparam int unsigned AREG_W = $clog2(AREG_NUM);
    localparam int unsigned CKPT_W = $clog2(CKPT_NUM);
    localparam int unsigned SLOT_W = (RN_WIDTH > 1) ? $clog2(RN_WIDTH) : 1;

    logic [RN_WIDTH-1:0][1:0][AREG_W-1:0] rn_src_i;
    logic [RN_WIDTH-1:0][1:0][PREG_W-1:0] rn_src_o;
    logic [RN_WIDTH-1:0]                  rn_we_i;
    logic [RN_WIDTH-1:0][AREG_W-1:0]      rn_dst_i;
    logic [RN_WIDTH-1:0][PREG_W-1:0]      rn_pdst_i;
    logic [RN_WIDTH-1:0][PREG_W-1:0]      rn_old_o;
    logic                                 ckpt_take_i;
    logic [SLOT_W-1:0]                    ckpt_slot_i;
    logic [CKPT_W-1:0]                    ckpt_id_o;
    logic                                 ckpt_full_o;
    logic                                 ckpt_rel_i;
    logic                                 restore_i;
    logic [CKPT_W-1:0]                    restore_id_i;
    logic [RN_WIDTH-1:0]                  cmt_we_i;
    logic [RN_WIDTH-1:0][AREG_W-1:0]      cmt_dst_i;
    logic [RN_WIDTH-1:0][PREG_W-1:0]      cmt_pdst_i;
    logic                                 flush_i;

    modport master (
        output rn_src_i, rn_we_i, rn_dst_i, rn_pdst_i, ckpt_take_i, ckpt_slot_i, ckpt_rel_i,
               restore_i, restore_id_i, cmt_we_i, cmt_dst_i, cmt_pdst_i, flush_i,
        input  rn_src_o, rn_old_o, ckpt_id_o, ckpt_full_o
    );

    modport slave (
        input  rn_src_i, rn_we_i, rn_dst_i, rn_pdst_i, ckpt_take_i, ckpt_slot_i, ckpt_rel_i,
               restore_i, restore_id_i, cmt_we_i, cmt_dst_i, cmt_pdst_i, flush_i,
        output rn_src_o, rn_old_o, ckpt_id_o, ckpt_full_o
    );
endinterface

// File: rtl/rename_rat_ckpt.sv
// Register alias table with speculative/committed maps and optional snapshot queue.
// Define BOOM_RAT_CKPT_EN to build the snapshot queue; otherwise restore acts as flush.
module rename_rat_ckpt #(
    parameter int unsigned RN_WIDTH = 2,
    parameter int unsigned AREG_NUM = 32,
    parameter int unsigned PREG_W   = 7,
    parameter int unsigned CKPT_NUM = 4
) (
    input logic              clk,
    input logic              rst,
    rename_rat_ckpt_if.slave bus
);
    localparam int unsigned AREG_W = $clog2(AREG_NUM);
    localparam int unsigned CKPT_W = $clog2(CKPT_NUM);

    typedef logic [AREG_NUM-1:0][PREG_W-1:0] map_t;

    map_t srat_q, srat_d, crat_q, crat_d, srat_ren;

    // Map lookup with forwarding from older slots of the same group; youngest match wins.
    function automatic logic [PREG_W-1:0] fwd_read(
        input map_t                            map,
        input logic [RN_WIDTH-1:0]             we,
        input logic [RN_WIDTH-1:0][AREG_W-1:0] dst,
        input logic [RN_WIDTH-1:0][PREG_W-1:0] pdst,
        input int                              slot,
        input logic [AREG_W-1:0]               areg
    );
        logic [PREG_W-1:0] val;
        val = map[areg];
        for (int i = 0; i < int'(RN_WIDTH); i++) begin
            if (i < slot && we[i] && dst[i] == areg) val = pdst[i];
        end
        if (areg == '0) val = '0;
        return val;
    endfunction

    always_comb begin
        for (int j = 0; j < int'(RN_WIDTH); j++) begin
            for (int k = 0; k < 2; k++) begin
                bus.rn_src_o[j][k] = fwd_read(srat_q, bus.rn_we_i, bus.rn_dst_i, bus.rn_pdst_i,
                                              j, bus.rn_src_i[j][k]);
            end
            bus.rn_old_o[j] = fwd_read(srat_q, bus.rn_we_i, bus.rn_dst_i, bus.rn_pdst_i,
                                       j, bus.rn_dst_i[j]);
        end
    end

    always_comb begin
        srat_ren = srat_q;
        crat_d   = crat_q;
        for (int i = 0; i < int'(RN_WIDTH); i++) begin
            if (bus.rn_we_i[i] && bus.rn_dst_i[i] != '0) srat_ren[bus.rn_dst_i[i]] = bus.rn_pdst_i[i];
            if (bus.cmt_we_i[i] && bus.cmt_dst_i[i] != '0) crat_d[bus.cmt_dst_i[i]] = bus.cmt_pdst_i[i];
        end
    end

`ifdef BOOM_RAT_CKPT_EN
    map_t                ckpt_q [CKPT_NUM];
    map_t                srat_snap;
    logic [CKPT_W-1:0]   head_q, head_d, tail_q, tail_d, head_rel, dist;
    logic [CKPT_W:0]     count_q, count_d;
    logic                take_ok, rel_ok, full;

    always_comb begin
        srat_snap = srat_q;
        for (int i = 0; i < int'(RN_WIDTH); i++) begin
            if (i <= int'(bus.ckpt_slot_i) && bus.rn_we_i[i] && bus.rn_dst_i[i] != '0) begin
                srat_snap[bus.rn_dst_i[i]] = bus.rn_pdst_i[i];
            end
        end
    end

    assign full            = (count_q == (CKPT_W+1)'(CKPT_NUM));
    assign bus.ckpt_full_o = full;
    assign bus.ckpt_id_o   = tail_q;
    assign take_ok         = bus.ckpt_take_i && !full && !bus.flush_i && !bus.restore_i;
    assign rel_ok          = bus.ckpt_rel_i && (count_q != '0) && !bus.flush_i;
    assign head_rel        = rel_ok ? head_q + CKPT_W'(1) : head_q;
    assign dist            = bus.restore_id_i - head_rel;

    always_comb begin
        head_d  = head_rel;
        tail_d  = tail_q;
        count_d = count_q;
        srat_d  = srat_ren;
        if (bus.flush_i) begin
            srat_d  = crat_d;
            head_d  = head_q;
            tail_d  = head_q;
            count_d = '0;
        end else if (bus.restore_i) begin
            srat_d = ckpt_q[bus.restore_id_i];
            tail_d = bus.restore_id_i + CKPT_W'(1);
            // Releasing the restored entry itself leaves nothing live behind it.
            if (rel_ok && bus.restore_id_i == head_q) count_d = '0;
            else                                      count_d = {1'b0, dist} + (CKPT_W+1)'(1);
        end else begin
            if (take_ok) tail_d = tail_q + CKPT_W'(1);
            if (take_ok && !rel_ok)      count_d = count_q + (CKPT_W+1)'(1);
            else if (!take_ok && rel_ok) count_d = count_q - (CKPT_W+1)'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && take_ok) ckpt_q[tail_q] <= srat_snap;
    end
`else
    logic unused_ckpt;
    assign unused_ckpt     = ^{bus.ckpt_take_i, bus.ckpt_slot_i, bus.ckpt_rel_i, bus.restore_id_i};
    assign bus.ckpt_full_o = 1'b0;
    assign bus.ckpt_id_o   = '0;

    always_comb begin
        srat_d = srat_ren;
        if (bus.flush_i || bus.restore_i) srat_d = crat_d;
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(AREG_NUM); i++) begin
                srat_q[i] <= PREG_W'(i);
                crat_q[i] <= PREG_W'(i);
            end
        end else begin
            srat_q <= srat_d;
            crat_q <= crat_d;
        end
    end
endmodule
